hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
Iterative multiply/divide unit that owns the HI/LO register pair for the single-cycle MIPS core. The control unit hands it decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests. The unit sequences a WIDTH-cycle shift-add or restoring-divide datapath. While a result is pending it drives stall back to the core so that no HI/LO access overtakes an in-flight operation.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH

Ports:
clk  input  1  rising-edge clock
rst_b  input  1  asynchronous active-low reset
start  input  1  request to begin a mul/div operation this cycle
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src_a  input  WIDTH  rs value (multiplicand / dividend)
src_b  input  WIDTH  rt value (multiplier / divisor)
mt_hi  input  1  MTHI request
mt_lo  input  1  MTLO request
mt_data  input  WIDTH  data for MTHI/MTLO
read_req  input  1  current instruction is MFHI or MFLO
busy  output  1  operation in flight
stall  output  1  core must hold PC and the current instruction
done  output  1  one-cycle pulse: HI/LO just updated by mul/div
div_by_zero  output  1  one-cycle pulse on DIV/DIVU with src_b == 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_b low, async): state IDLE; hi = lo = 0; busy = done = div_by_zero = 0; counter and working registers cleared. Reset mid-operation aborts with no HI/LO update.
- States:
  - IDLE: start accepted here only. Latch |src_a| and |src_b| for signed ops, raw values for unsigned. Latch result-sign flags. Load counter = WIDTH. Go to RUN.
  - DIV/DIVU with src_b == 0 instead stays in IDLE: div_by_zero pulses the next cycle, hi/lo unchanged, done not asserted.
  - RUN: one iteration per cycle; counter decrements. After WIDTH iterations go to FIX.
    - Multiply: unsigned shift-add into a 2*WIDTH accumulator.
    - Divide: restoring divide; quotient and remainder are unsigned magnitudes.
  - FIX: one cycle.
    - Signed multiply: negate the 2*WIDTH product if operand signs differ.
    - Signed divide: negate the quotient if signs differ; the remainder takes the dividend's sign.
    - Write hi = product[2W-1:W] and lo = product[W-1:0], or hi = remainder and lo = quotient, at this edge. Assert done for the following cycle. Return to IDLE.
- Latency: start sampled at edge 0; busy high from edge 0 until edge WIDTH+1; hi/lo valid and busy low after edge WIDTH+1 (33 cycles at WIDTH=32).
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0 (wraps, no flag).
- busy is a registered output.
- stall = busy & (read_req | start | mt_hi | mt_lo), combinational. A request arriving while busy is ignored and must be re-presented by the stalled core. A new start is never accepted in FIX.
- MTHI/MTLO in IDLE: write hi/lo at the next edge. If both are asserted, both are written.
- start together with mt_hi/mt_lo in IDLE: start wins and the mt write is dropped (illegal from a correct decoder).
- hi/lo are always readable; outputs are direct register values and are not bypassed.
- done and div_by_zero are never high simultaneously.

Test Plan:
- Reset, then MULT src_a=0xFFFFFFFD (-3), src_b=5 -> busy 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, one-cycle done pulse.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 33 cycles.
- DIV -7 (0xFFFFFFF9) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- MTHI 0x1234, then DIVU 5/0 -> div_by_zero pulse, busy stays 0, hi=0x1234 unchanged, no done.
- MULTU 6x7, then read_req asserted at cycle 3 -> stall high until busy falls; afterwards lo=42, hi=0. A start asserted mid-run is ignored, with stall high.
- MULT in flight, drop rst_b at cycle 10 -> busy=0, hi=lo=0 immediately. After release a new MULTU 2x3 completes with lo=6.

Source files
------------

// File: rtl/hilo_muldiv_if.sv
// Core <-> HI/LO multiply/divide unit request and status bundle.
// The core drives requests; the unit drives status and the HI/LO registers.
interface hilo_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             mt_hi;
  logic             mt_lo;
  logic [WIDTH-1:0] mt_data;
  logic             read_req;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, mt_hi, mt_lo, mt_data, read_req,
    input  busy, stall, done, div_by_zero, hi, lo
  );
  modport slave (
    input  start, op, src_a, src_b, mt_hi, mt_lo, mt_data, read_req,
    output busy, stall, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: WIDTH-cycle shift-add or
// restoring divide on magnitudes, with a one-cycle sign fix-up before write-back.
module hilo_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_b,
   hilo_muldiv_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t               r_state;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_opnd;
   logic                 r_is_div;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_dbz;

   logic                 w_sgn, w_div, w_a_neg, w_b_neg, w_zero_div;
   logic [WIDTH-1:0]     w_abs_a, w_abs_b;
   logic [WIDTH:0]       w_msum, w_shift, w_diff;
   logic                 w_ge;
   logic [2*WIDTH-1:0]   w_mul_next, w_div_next, w_prod;
   logic [WIDTH-1:0]     w_quo, w_rem;

   assign w_sgn      = ~bus.op[0];
   assign w_div      = bus.op[1];
   assign w_a_neg    = w_sgn & bus.src_a[WIDTH-1];
   assign w_b_neg    = w_sgn & bus.src_b[WIDTH-1];
   assign w_abs_a    = w_a_neg ? -bus.src_a : bus.src_a;
   assign w_abs_b    = w_b_neg ? -bus.src_b : bus.src_b;
   assign w_zero_div = w_div & (bus.src_b == '0);

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
   assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
   assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

   // Divide: acc = {remainder, dividend/quotient}; quotient bits shift in at the bottom.
   assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_diff     = w_shift - {1'b0, r_opnd};
   assign w_ge       = ~w_diff[WIDTH];
   assign w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

   assign w_prod = r_neg_q ? -r_acc : r_acc;
   assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dbz    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_dbz  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  if (w_zero_div) begin
                     r_dbz <= 1'b1;
                  end else begin
                     r_acc    <= {{WIDTH{1'b0}}, (w_div ? w_abs_a : w_abs_b)};
                     r_opnd   <= w_div ? w_abs_b : w_abs_a;
                     r_is_div <= w_div;
                     r_neg_q  <= w_a_neg ^ w_b_neg;
                     r_neg_r  <= w_a_neg;
                     r_cnt    <= CW'(WIDTH);
                     r_busy   <= 1'b1;
                     r_state  <= S_RUN;
                  end
               end else begin
                  if (bus.mt_hi) r_hi <= bus.mt_data;
                  if (bus.mt_lo) r_lo <= bus.mt_data;
               end
            end
            S_RUN: begin
               r_acc <= r_is_div ? w_div_next : w_mul_next;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) r_state <= S_FIX;
            end
            S_FIX: begin
               if (r_is_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  r_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod[WIDTH-1:0];
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.stall       = r_busy & (bus.read_req | bus.start | bus.mt_hi | bus.mt_lo);
   assign bus.done        = r_done;
   assign bus.div_by_zero = r_dbz;
   assign bus.hi          = r_hi;
   assign bus.lo          = r_lo;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized scoreboard bench for hilo_muldiv_unit: expected HI/LO from a
// 64-bit arithmetic reference model, popped by a monitor on done/div_by_zero.
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  typedef struct {
    bit         dbz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  hilo_muldiv_if #(.WIDTH(W)) bus();

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural operands.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] e_hi, output logic [W-1:0] e_lo);
    longint p, q, r;
    case (op)
      2'b00: begin p = longint'($signed(a)) * longint'($signed(b)); e_hi = p[63:32]; e_lo = p[31:0]; end
      2'b01: begin p = longint'({32'b0, a}) * longint'({32'b0, b}); e_hi = p[63:32]; e_lo = p[31:0]; end
      2'b10: begin q = longint'($signed(a)) / longint'($signed(b));
                   r = longint'($signed(a)) % longint'($signed(b));
                   e_hi = r[31:0]; e_lo = q[31:0]; end
      default: begin q = longint'({32'b0, a}) / longint'({32'b0, b});
                     r = longint'({32'b0, a}) % longint'({32'b0, b});
                     e_hi = r[31:0]; e_lo = q[31:0]; end
    endcase
  endtask

  // Monitor: every done / div_by_zero pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_b && (bus.done || bus.div_by_zero)) begin
      exp_t e;
      if (bus.done && bus.div_by_zero) begin
        n_cmp++; n_bad++;
        $display("FAIL pulse_excl: done and div_by_zero both high");
      end else if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_unexpected: pulse done=%b dbz=%b with empty scoreboard", bus.done, bus.div_by_zero);
      end else begin
        e = sb_q.pop_front();
        chk("sb_kind", {31'b0, bus.div_by_zero}, {31'b0, e.dbz});
        chk("sb_hi", bus.hi, e.hi);
        chk("sb_lo", bus.lo, e.lo);
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int rd_at, input int st_at);
    logic [W-1:0] e_hi, e_lo;
    exp_t e;
    bit ok, rd, st;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    if (op[1] && b == '0) begin
      e.dbz = 1'b1; e.hi = m_hi; e.lo = m_lo; sb_q.push_back(e);
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("dbz_busy", {31'b0, bus.busy}, 32'd0);
      @(posedge clk); #1;
      chk("dbz_hi", bus.hi, m_hi);
      chk("dbz_lo", bus.lo, m_lo);
      return;
    end
    model(op, a, b, e_hi, e_lo);
    e.dbz = 1'b0; e.hi = e_hi; e.lo = e_lo; sb_q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    ok = 1'b1;
    for (int k = 1; k <= W + 1; k++) begin
      if (bus.busy !== 1'b1) ok = 1'b0;
      rd = (rd_at != 0) && (k >= rd_at);
      st = (k == st_at);
      bus.read_req = rd;
      if (st) begin
        bus.start = 1'b1; bus.op = 2'b11; bus.src_a = $urandom; bus.src_b = '0;
      end
      #1;
      if (rd || st) chk("stall_busy", {31'b0, bus.stall}, 32'd1);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    chk("busy_window", {31'b0, ok}, 32'd1);
    chk("busy_fall", {31'b0, bus.busy}, 32'd0);
    if (rd_at != 0) chk("stall_release", {31'b0, bus.stall}, 32'd0);
    bus.read_req = 1'b0;
    chk("res_hi", bus.hi, e_hi);
    chk("res_lo", bus.lo, e_lo);
    m_hi = e_hi; m_lo = e_lo;
  endtask

  task automatic mt_write(input bit wh, input bit wl, input logic [W-1:0] d);
    @(posedge clk); #1;
    bus.mt_hi = wh; bus.mt_lo = wl; bus.mt_data = d;
    @(posedge clk); #1;
    bus.mt_hi = 1'b0; bus.mt_lo = 1'b0;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    chk("mt_hi", bus.hi, m_hi);
    chk("mt_lo", bus.lo, m_lo);
  endtask

  initial begin
    logic [1:0] rop;
    logic [W-1:0] ra, rb;
    bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0;
    bus.mt_hi = 1'b0; bus.mt_lo = 1'b0; bus.mt_data = '0; bus.read_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    rst_b = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(2'b11, 32'd100, 32'd7, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    mt_write(1'b1, 1'b0, 32'h1234);
    run_op(2'b11, 32'd5, 32'd0, 0, 0);
    run_op(2'b01, 32'd6, 32'd7, 3, 12);
    mt_write(1'b1, 1'b1, 32'hCAFE_F00D);

    // Abort mid-operation: reset clears everything and no result is posted.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'hFFFF_FFFD; bus.src_b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    run_op(2'b01, 32'd2, 32'd3, 0, 0);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) mt_write(1'($urandom), 1'($urandom), $urandom);
      run_op(rop, ra, rb, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, W)) : 0, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
